// File: rtl/dlsc_uart_pkg.sv
// Shared definitions for the buffered UART transmitter: parity modes, FSM states
// and the ceiling-log2 helper used for counter and pointer widths.
package dlsc_uart_pkg;

  localparam logic [2:0] PAR_NONE  = 3'd0;
  localparam logic [2:0] PAR_ODD   = 3'd1;
  localparam logic [2:0] PAR_EVEN  = 3'd2;
  localparam logic [2:0] PAR_MARK  = 3'd3;
  localparam logic [2:0] PAR_SPACE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_HOLD,
    ST_BREAK
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dlsc_uart_tx_fifo.sv
// Synchronous transmit FIFO with registered occupancy; a push while full is
// dropped even if a pop happens in the same cycle.
module dlsc_uart_tx_fifo
  import dlsc_uart_pkg::*;
#(
  parameter int DATA  = 8,
  parameter int DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [DATA-1:0]             wr_data,
  input  logic                        rd_en,
  output logic [DATA-1:0]             rd_data,
  output logic                        full,
  output logic                        empty,
  output logic [clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [DATA-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/dlsc_uart_tx_ext.sv
// Buffered UART transmitter with per-frame format, break generation and an
// RS-485 driver-enable hold after the last stop bit.
module dlsc_uart_tx_ext
  import dlsc_uart_pkg::*;
#(
  parameter int DATA       = 8,
  parameter int DEPTH      = 16,
  parameter int OVERSAMPLE = 16,
  parameter int HOLD       = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clk_en,
  input  logic [3:0]                cfg_bits,
  input  logic [2:0]                cfg_parity,
  input  logic                      cfg_stop2,
  input  logic                      cfg_break,
  input  logic                      valid,
  input  logic [DATA-1:0]           data,
  output logic                      ready,
  output logic [clog2(DEPTH+1)-1:0] count,
  output logic                      busy,
  output logic                      tx,
  output logic                      tx_en
);

  localparam int DW = (OVERSAMPLE > 1) ? clog2(OVERSAMPLE) : 1;

  logic [DW-1:0]   div;
  logic            tick;

  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_pop;
  logic [DATA-1:0] fifo_rd_data;

  state_t          state, state_d;
  logic            tx_q, tx_d;
  logic            tx_en_q, tx_en_d;
  logic [DATA-1:0] shift, shift_d;
  logic [3:0]      bit_idx, bit_idx_d;
  logic [3:0]      f_bits, f_bits_d;
  logic [2:0]      f_par, f_par_d;
  logic            f_stop2, f_stop2_d;
  logic            par_acc, par_acc_d;
  logic            stop_cnt, stop_cnt_d;
  logic [3:0]      hold_cnt, hold_cnt_d;

  logic [3:0]      bits_clamped;
  logic [2:0]      par_norm;
  logic            load;
  logic            brk;

  dlsc_uart_tx_fifo #(
    .DATA  (DATA),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (valid),
    .wr_data (data),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  assign ready = !fifo_full;
  assign busy  = (state != ST_IDLE);
  assign tx    = tx_q;
  assign tx_en = tx_en_q;
  assign tick  = clk_en && (div == DW'(OVERSAMPLE - 1));

  // Free-running divider so the bit grid never re-phases to a push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (clk_en) begin
      div <= tick ? '0 : div + DW'(1);
    end
  end

  always_comb begin
    bits_clamped = cfg_bits;
    if (cfg_bits < 4'd5) begin
      bits_clamped = 4'd5;
    end else if (cfg_bits > 4'(DATA)) begin
      bits_clamped = 4'(DATA);
    end
    par_norm = (cfg_parity > PAR_SPACE) ? PAR_NONE : cfg_parity;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tx_q     <= 1'b1;
      tx_en_q  <= 1'b0;
      shift    <= '0;
      bit_idx  <= '0;
      f_bits   <= 4'd5;
      f_par    <= PAR_NONE;
      f_stop2  <= 1'b0;
      par_acc  <= 1'b0;
      stop_cnt <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_d;
      tx_q     <= tx_d;
      tx_en_q  <= tx_en_d;
      shift    <= shift_d;
      bit_idx  <= bit_idx_d;
      f_bits   <= f_bits_d;
      f_par    <= f_par_d;
      f_stop2  <= f_stop2_d;
      par_acc  <= par_acc_d;
      stop_cnt <= stop_cnt_d;
      hold_cnt <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d    = state;
    tx_d       = tx_q;
    tx_en_d    = tx_en_q;
    shift_d    = shift;
    bit_idx_d  = bit_idx;
    f_bits_d   = f_bits;
    f_par_d    = f_par;
    f_stop2_d  = f_stop2;
    par_acc_d  = par_acc;
    stop_cnt_d = stop_cnt;
    hold_cnt_d = hold_cnt;
    fifo_pop   = 1'b0;
    load       = 1'b0;
    brk        = 1'b0;

    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (cfg_break) begin
            brk = 1'b1;
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            tx_d    = 1'b1;
            tx_en_d = 1'b0;
          end
        end
        ST_START: begin
          tx_d      = shift[0];
          par_acc_d = shift[0];
          shift_d   = shift >> 1;
          bit_idx_d = 4'd1;
          state_d   = ST_DATA;
        end
        ST_DATA: begin
          if (bit_idx < f_bits) begin
            tx_d      = shift[0];
            par_acc_d = par_acc ^ shift[0];
            shift_d   = shift >> 1;
            bit_idx_d = bit_idx + 4'd1;
          end else if (f_par != PAR_NONE) begin
            state_d = ST_PARITY;
            case (f_par)
              PAR_ODD:  tx_d = ~par_acc;
              PAR_EVEN: tx_d = par_acc;
              PAR_MARK: tx_d = 1'b1;
              default:  tx_d = 1'b0;
            endcase
          end else begin
            state_d    = ST_STOP;
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
          end
        end
        ST_PARITY: begin
          state_d    = ST_STOP;
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
        ST_STOP: begin
          if (f_stop2 && !stop_cnt) begin
            stop_cnt_d = 1'b1;
          end else if (cfg_break) begin
            brk = 1'b1;
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else if (HOLD > 0) begin
            state_d    = ST_HOLD;
            tx_d       = 1'b1;
            hold_cnt_d = 4'(HOLD - 1);
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
            tx_en_d = 1'b0;
          end
        end
        ST_HOLD: begin
          if (cfg_break) begin
            brk = 1'b1;
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else if (hold_cnt == '0) begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
            tx_en_d = 1'b0;
          end else begin
            hold_cnt_d = hold_cnt - 4'd1;
          end
        end
        ST_BREAK: begin
          if (cfg_break) begin
            tx_d = 1'b0;
          end else begin
            state_d    = ST_STOP;
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
            f_stop2_d  = cfg_stop2;
          end
        end
        default: begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
          tx_en_d = 1'b0;
        end
      endcase
    end

    // Format is captured at the pop so mid-frame config writes only hit the next frame.
    if (load) begin
      fifo_pop  = 1'b1;
      shift_d   = fifo_rd_data;
      f_bits_d  = bits_clamped;
      f_par_d   = par_norm;
      f_stop2_d = cfg_stop2;
      tx_d      = 1'b0;
      tx_en_d   = 1'b1;
      state_d   = ST_START;
    end
    if (brk) begin
      tx_d    = 1'b0;
      tx_en_d = 1'b1;
      state_d = ST_BREAK;
    end
  end

endmodule

// File: tb/tb_dlsc_uart_tx_ext.sv
// Directed bench for dlsc_uart_tx_ext with OVERSAMPLE=1 so every clk_en pulse is
// a bit tick; DEPTH=4 to reach the full condition cheaply.
module tb_dlsc_uart_tx_ext;

  logic       clk;
  logic       rst_n;
  logic       clk_en;
  logic [3:0] cfg_bits;
  logic [2:0] cfg_parity;
  logic       cfg_stop2;
  logic       cfg_break;
  logic       valid;
  logic [7:0] data;
  logic       ready;
  logic [2:0] count;
  logic       busy;
  logic       tx;
  logic       tx_en;

  int checks = 0;
  int errors = 0;

  dlsc_uart_tx_ext #(
    .DATA       (8),
    .DEPTH      (4),
    .OVERSAMPLE (1),
    .HOLD       (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .cfg_bits   (cfg_bits),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .cfg_break  (cfg_break),
    .valid      (valid),
    .data       (data),
    .ready      (ready),
    .count      (count),
    .busy       (busy),
    .tx         (tx),
    .tx_en      (tx_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n     = 1'b0;
    clk_en    = 1'b0;
    valid     = 1'b0;
    data      = 8'h00;
    cfg_break = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    valid = 1'b1;
    data  = d;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  // Waits (bounded) for the start bit, then records n consecutive tick samples.
  task automatic capture(input int n, output logic [63:0] ctx, output logic [63:0] cen,
                         output bit to);
    ctx = '1;
    cen = '0;
    to  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (tx === 1'b0) begin
        to = 1'b0;
        break;
      end
    end
    if (!to) begin
      ctx[0] = tx;
      cen[0] = tx_en;
      for (int i = 1; i < n; i++) begin
        @(posedge clk);
        #1;
        ctx[i] = tx;
        cen[i] = tx_en;
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (tx !== 1'b1 || tx_en !== 1'b0 || ready !== 1'b1 || count !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: tx=%b tx_en=%b ready=%b count=%0d busy=%b, want 1 0 1 0 0",
               tx, tx_en, ready, count, busy);
    end
  endtask

  task automatic test_single_frame();
    logic [63:0] ctx, cen;
    bit          to;
    // 0xA5 LSB first: start, 1,0,1,0,0,1,0,1, stop, hold, idle
    logic [11:0] exp_tx = 12'b1111_0100_1010;
    logic [11:0] exp_en = 12'b0111_1111_1111;
    cfg_bits = 4'd8; cfg_parity = 3'd0; cfg_stop2 = 1'b0;
    clk_en = 1'b1;
    push_word(8'hA5);
    capture(12, ctx, cen, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL single_start: no start bit within 40 cycles");
      return;
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (ctx[i] !== exp_tx[i] || cen[i] !== exp_en[i]) begin
        errors++;
        $display("FAIL single_bit%0d: tx=%b tx_en=%b, want tx=%b tx_en=%b",
                 i, ctx[i], cen[i], exp_tx[i], exp_en[i]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] ctx, cen;
    bit          to;
    logic [7:0]  words [4];
    // even parity of low 7 bits: 0x00->0, 0x7F->1, 0x55->0, 0x01->1
    logic [3:0]  par = 4'b1010;
    logic [43:0] exp;
    words = '{8'h00, 8'hFF, 8'h55, 8'h81};
    for (int k = 0; k < 4; k++) begin
      exp[k*11]      = 1'b0;
      for (int j = 0; j < 7; j++) exp[k*11 + 1 + j] = words[k][j];
      exp[k*11 + 8]  = par[k];
      exp[k*11 + 9]  = 1'b1;
      exp[k*11 + 10] = 1'b1;
    end
    clk_en = 1'b0;
    cfg_bits = 4'd7; cfg_parity = 3'd2; cfg_stop2 = 1'b1;
    for (int k = 0; k < 4; k++) push_word(words[k]);
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL b2b_count_full: count=%0d, want 4", count);
    end
    clk_en = 1'b1;
    capture(44, ctx, cen, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL b2b_start: no start bit within 40 cycles");
      return;
    end
    for (int i = 0; i < 44; i++) begin
      checks++;
      if (ctx[i] !== exp[i] || cen[i] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_bit%0d: tx=%b tx_en=%b, want tx=%b tx_en=1", i, ctx[i], cen[i], exp[i]);
      end
    end
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL b2b_count_empty: count=%0d, want 0", count);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_fifo_full();
    bool_chk: begin end
    clk_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      valid = 1'b1;
      data  = 8'(8'h10 + i);
      @(posedge clk);
      #1;
      if (i == 2) begin
        checks++;
        if (ready !== 1'b1) begin
          errors++;
          $display("FAIL full_ready3: ready=%b, want 1", ready);
        end
      end
      if (i == 3) begin
        checks++;
        if (ready !== 1'b0) begin
          errors++;
          $display("FAIL full_ready4: ready=%b, want 0", ready);
        end
      end
    end
    valid = 1'b0;
    checks++;
    if (count !== 3'd4 || ready !== 1'b0) begin
      errors++;
      $display("FAIL full_count: count=%0d ready=%b, want 4 0", count, ready);
    end
    // push attempt while full, coinciding with a pop on the first tick
    valid  = 1'b1;
    data   = 8'hEE;
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    valid  = 1'b0;
    clk_en = 1'b0;
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL full_push_pop: count=%0d, want 3", count);
    end
    do_reset();
    checks++;
    if (count !== 3'd0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL full_flush: count=%0d ready=%b, want 0 1", count, ready);
    end
  endtask

  task automatic test_parity_modes();
    logic [63:0] ctx, cen;
    bit          to;
    // bits, mode, stop index, expected parity (0x03 has two ones in its low 5 bits)
    logic [3:0]  t_bits [5] = '{4'd5, 4'd5, 4'd5, 4'd2, 4'd5};
    logic [2:0]  t_mode [5] = '{3'd1, 3'd3, 3'd4, 3'd2, 3'd6};
    int          t_stop [5] = '{7, 7, 7, 7, 6};
    logic        t_par  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [4:0]  dbits = 5'b00011;
    clk_en = 1'b1;
    cfg_stop2 = 1'b0;
    for (int m = 0; m < 5; m++) begin
      cfg_bits   = t_bits[m];
      cfg_parity = t_mode[m];
      push_word(8'h03);
      capture(10, ctx, cen, to);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL par%0d_start: no start bit within 40 cycles", m);
        return;
      end
      for (int j = 0; j < 5; j++) begin
        checks++;
        if (ctx[1 + j] !== dbits[j]) begin
          errors++;
          $display("FAIL par%0d_data%0d: tx=%b, want %b", m, j, ctx[1 + j], dbits[j]);
        end
      end
      if (t_stop[m] == 7) begin
        checks++;
        if (ctx[6] !== t_par[m]) begin
          errors++;
          $display("FAIL par%0d_parity: tx=%b, want %b", m, ctx[6], t_par[m]);
        end
      end
      checks++;
      if (ctx[t_stop[m]] !== 1'b1 || cen[t_stop[m] + 2] !== 1'b0) begin
        errors++;
        $display("FAIL par%0d_stop: tx=%b tx_en_after=%b, want 1 0",
                 m, ctx[t_stop[m]], cen[t_stop[m] + 2]);
      end
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_break();
    logic [63:0] ctx;
    logic [63:0] exp;
    logic [7:0]  wa = 8'h3C;
    logic [7:0]  wb = 8'hC3;
    bit          to;
    exp = '1;
    exp[0] = 1'b0;
    for (int j = 0; j < 8; j++) exp[1 + j] = wa[j];
    for (int i = 10; i < 30; i++) exp[i] = 1'b0;
    exp[31] = 1'b0;
    for (int j = 0; j < 8; j++) exp[32 + j] = wb[j];
    clk_en = 1'b0;
    cfg_bits = 4'd8; cfg_parity = 3'd0; cfg_stop2 = 1'b0; cfg_break = 1'b0;
    push_word(wa);
    push_word(wb);
    clk_en = 1'b1;
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (tx === 1'b0) begin
        to = 1'b0;
        break;
      end
    end
    checks++;
    if (to) begin
      errors++;
      $display("FAIL brk_start: no start bit within 40 cycles");
      return;
    end
    ctx = '1;
    for (int i = 0; i < 41; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      ctx[i] = tx;
      if (i == 3) cfg_break = 1'b1;
      if (i == 29) cfg_break = 1'b0;
      if (i == 20) begin
        checks++;
        if (count !== 3'd1 || tx_en !== 1'b1) begin
          errors++;
          $display("FAIL brk_hold_fifo: count=%0d tx_en=%b, want 1 1", count, tx_en);
        end
      end
    end
    for (int i = 0; i < 41; i++) begin
      checks++;
      if (ctx[i] !== exp[i]) begin
        errors++;
        $display("FAIL brk_bit%0d: tx=%b, want %b", i, ctx[i], exp[i]);
      end
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    logic [63:0] ctx, cen;
    bit          to;
    bit          bad;
    clk_en = 1'b0;
    cfg_bits = 4'd8; cfg_parity = 3'd0; cfg_stop2 = 1'b0;
    push_word(8'h00);
    push_word(8'h00);
    clk_en = 1'b1;
    capture(4, ctx, cen, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL rst_start: no start bit within 40 cycles");
      return;
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || tx_en !== 1'b0 || ready !== 1'b1 || count !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: tx=%b tx_en=%b ready=%b count=%0d busy=%b, want 1 0 1 0 0",
               tx, tx_en, ready, count, busy);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1 || tx_en !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || count !== 3'd0) begin
      errors++;
      $display("FAIL rst_residual: line_active=%b count=%0d, want 0 0", bad, count);
    end
  endtask

  initial begin
    cfg_bits   = 4'd8;
    cfg_parity = 3'd0;
    cfg_stop2  = 1'b0;
    do_reset();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_fifo_full();
    test_parity_modes();
    test_break();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
